sirali_kilit_denetleyici: RTL and testbench
===========================================

// Module: sirali_kilit_denetleyici
// PURPOSE
//  Sequential, parametrised multi-lock controller. Accepts one (sag, sol) step pair per lock over a
//  valid/ready handshake and derives a per-lock code. Once every lock has a step, all codes are
//  compared against the programmed passwords.
//  Tracks failed attempts and enforces a timed lockout. Sits between the keypad/step front-end and the door actuator.
// PARAMETERS
//  KILIT_SAYISI  2   number of locks (steps per attempt), >=1
//  SAG_W         3   width of right-step input
//  SOL_W         2   width of left-step input
//  SIFRE_W       6   width of one lock password; must be >= SAG_W+3
//  MAX_DENEME    3   failed attempts before lockout, >=1
//  CEZA_SURESI   16  lockout length in clk cycles, >=1
// PORTS
//  clk             in   1                    clock, rising edge
//  rst             in   1                    async active-high reset
//  adim_gecerli    in   1                    step valid
//  adim_hazir      out  1                    step ready
//  sag_adim        in   SAG_W                right-step count of current step
//  sol_adim        in   SOL_W                left-step count of current step
//  kilit_sifreler  in   KILIT_SAYISI*SIFRE_W passwords; lock i at [i*SIFRE_W +: SIFRE_W]
//  iptal           in   1                    abort current entry
//  kapat           in   1                    relock after open
//  kilitler_acik   out  1                    all locks open (registered)
//  hata            out  1                    1-cycle pulse on failed attempt
//  kilitli         out  1                    lockout active
//  kalan_deneme    out  $clog2(MAX_DENEME+1) attempts left
// BEHAVIOUR
//  Code per step: d = (sag - 2*sol) mod 2^SAG_W (sol zero-extended); kod = d*5, zero-extended to SIFRE_W.
//  Step k (0-based within attempt) is lock k. eslesme[k] = (kod == sifre slice k), latched on the accept cycle.
//  Accept = adim_gecerli & adim_hazir. adim_hazir = 1 only in GIRIS. Inputs are ignored when not ready.
//  FSM states: GIRIS, KONTROL, ACIK, KILITLI. Reset -> GIRIS.
//  Reset values: adim_hazir=1, step idx=0, eslesme=0, kilitler_acik=0, hata=0, kilitli=0, kalan_deneme=MAX_DENEME.
//  GIRIS:
//   - Accept -> store eslesme[idx], idx++.
//   - Accept of the last step (idx==KILIT_SAYISI-1) -> KONTROL next cycle.
//   - iptal (priority over accept in the same cycle) -> idx=0, eslesme cleared; kalan_deneme unchanged, no hata.
//  KONTROL (1 cycle, adim_hazir=0):
//   - All eslesme=1 -> ACIK; kilitler_acik=1 from the next cycle; kalan_deneme reloads to MAX_DENEME.
//   - Otherwise hata=1 for exactly one cycle and kalan_deneme decrements.
//     If the result is 0 -> KILITLI with penalty counter = CEZA_SURESI; else -> GIRIS with idx=0.
//  ACIK: kilitler_acik held at 1. kapat -> GIRIS; kilitler_acik=0 next cycle, idx=0. iptal has no effect.
//  KILITLI:
//   - kilitli=1, adim_hazir=0; kapat/iptal ignored.
//   - Counter decrements each cycle; after exactly CEZA_SURESI cycles in KILITLI -> GIRIS with kalan_deneme=MAX_DENEME.
//  Latency: last accept -> kilitler_acik or hata asserted 2 clk edges later.
//  Passwords are sampled on each accept cycle; a kilit_sifreler change mid-attempt affects only later steps.
//  rst mid-operation: all state is immediately returned to reset values (async), including lockout.
//  kalan_deneme saturates; it never wraps below 0.
// STRUCTURE
//  Shared package: FSM state encodings (GIRIS/KONTROL/ACIK/KILITLI), code multiplier constant 5.
//  Sub-module kilit_kod_hesaplayici: combinational (sag, sol) -> kod[SIFRE_W-1:0], one instance on the step path.
//  Top: FSM, step index, eslesme register vector, attempt and penalty counters.
// TESTING (defaults; sifre[5:0]=15, sifre[11:6]=20)
//  1. Steps (5,1) then (2,3) -> kod 15,20. kilitler_acik=1 two edges after the 2nd accept; kalan_deneme=3.
//  2. While open, pulse kapat -> kilitler_acik=0 next cycle, adim_hazir=1. Then steps (5,1),(0,0) -> hata pulse, kalan_deneme=2.
//  3. Three wrong attempts -> kilitli=1 for exactly 16 cycles, adim_hazir=0 and adim_gecerli ignored throughout.
//     Then kalan_deneme=3, GIRIS.
//  4. Step (5,1), then iptal asserted together with a valid (2,3) -> no accept, idx=0, no hata.
//     A full correct pair afterwards opens the locks.
//  5. Assert rst during KILITLI and during ACIK -> all outputs at reset values immediately, without waiting for a clk edge.
//  6. Wrap case: sag=0, sol=3 -> d=2, kod=10. With sifre[5:0]=10, step (0,3) then (2,3) -> open.

Source files
------------

// File: rtl/sirali_kilit_denetleyici_pkg.sv
// Shared definitions for the sequential multi-lock controller.
//   - FSM state encodings (entry, check, open, lockout)
//   - multiplier applied to the step difference to form a lock code
package sirali_kilit_denetleyici_pkg;

    localparam logic [1:0] GIRIS   = 2'd0;  // collecting steps
    localparam logic [1:0] KONTROL = 2'd1;  // one-cycle compare of all locks
    localparam logic [1:0] ACIK    = 2'd2;  // all locks open, waiting for relock
    localparam logic [1:0] KILITLI = 2'd3;  // timed lockout after too many failures

    localparam int KOD_CARPAN = 5;

endpackage

// File: rtl/sirali_kilit_denetleyici_kod.sv
// Combinational step-to-code converter.
//   i_sag  : right-step count
//   i_sol  : left-step count
//   o_kod  : ((sag - 2*sol) mod 2^SAG_W) * KOD_CARPAN, zero-extended
module kilit_kod_hesaplayici
    import sirali_kilit_denetleyici_pkg::*;
#(
    parameter int SAG_W   = 3,
    parameter int SOL_W   = 2,
    parameter int SIFRE_W = 6
)(
    input  logic [SAG_W-1:0]   i_sag,
    input  logic [SOL_W-1:0]   i_sol,
    output logic [SIFRE_W-1:0] o_kod
);

    localparam int TW = SAG_W + SOL_W + 1;

    logic [TW-1:0]    w_fark;
    logic [SAG_W-1:0] w_d;

    // Subtract in a wide word, then keep the low SAG_W bits for the modulo wrap.
    assign w_fark = TW'(i_sag) - (TW'(i_sol) << 1);
    assign w_d    = w_fark[SAG_W-1:0];
    // SIFRE_W >= SAG_W+3 guarantees d*5 never overflows the code width.
    assign o_kod  = SIFRE_W'(w_d) * SIFRE_W'(KOD_CARPAN);

endmodule

// File: rtl/sirali_kilit_denetleyici.sv
// Sequential multi-lock controller.
//   i_clk, i_rst            : clock, async active-high reset
//   i_adim_gecerli/o_adim_hazir : step handshake (one step per lock)
//   i_sag_adim, i_sol_adim  : current step
//   i_kilit_sifreler        : packed passwords, lock i at [i*SIFRE_W +: SIFRE_W]
//   i_iptal, i_kapat        : abort entry, relock after open
//   o_kilitler_acik         : all locks open (registered)
//   o_hata                  : one-cycle pulse on failed attempt
//   o_kilitli               : lockout active
//   o_kalan_deneme          : attempts left before lockout
module sirali_kilit_denetleyici
    import sirali_kilit_denetleyici_pkg::*;
#(
    parameter int KILIT_SAYISI = 2,
    parameter int SAG_W        = 3,
    parameter int SOL_W        = 2,
    parameter int SIFRE_W      = 6,
    parameter int MAX_DENEME   = 3,
    parameter int CEZA_SURESI  = 16,
    localparam int KALAN_W     = $clog2(MAX_DENEME + 1)
)(
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_adim_gecerli,
    output logic                            o_adim_hazir,
    input  logic [SAG_W-1:0]                i_sag_adim,
    input  logic [SOL_W-1:0]                i_sol_adim,
    input  logic [KILIT_SAYISI*SIFRE_W-1:0] i_kilit_sifreler,
    input  logic                            i_iptal,
    input  logic                            i_kapat,
    output logic                            o_kilitler_acik,
    output logic                            o_hata,
    output logic                            o_kilitli,
    output logic [KALAN_W-1:0]              o_kalan_deneme
);

    localparam int IDX_W  = (KILIT_SAYISI > 1) ? $clog2(KILIT_SAYISI) : 1;
    localparam int CEZA_W = $clog2(CEZA_SURESI + 1);

    logic [1:0]              r_durum;
    logic [IDX_W-1:0]        r_idx;
    logic [KILIT_SAYISI-1:0] r_eslesme;
    logic                    r_acik;
    logic                    r_hata;
    logic [KALAN_W-1:0]      r_kalan;
    logic [CEZA_W-1:0]       r_ceza;

    logic [SIFRE_W-1:0]      w_kod;
    logic [SIFRE_W-1:0]      w_sifre;
    logic                    w_hazir;
    logic                    w_kabul;
    logic                    w_son_adim;
    logic [KALAN_W-1:0]      w_kalan_yeni;

    kilit_kod_hesaplayici #(
        .SAG_W   (SAG_W),
        .SOL_W   (SOL_W),
        .SIFRE_W (SIFRE_W)
    ) u_kod (
        .i_sag (i_sag_adim),
        .i_sol (i_sol_adim),
        .o_kod (w_kod)
    );

    assign w_hazir      = (r_durum == GIRIS);
    assign w_kabul      = i_adim_gecerli & w_hazir;
    assign w_son_adim   = (r_idx == IDX_W'(KILIT_SAYISI - 1));
    // Password for the current lock is taken live, so mid-attempt changes only hit later steps.
    assign w_sifre      = i_kilit_sifreler[int'(r_idx)*SIFRE_W +: SIFRE_W];
    // Saturating decrement: never wraps below zero.
    assign w_kalan_yeni = (r_kalan == '0) ? '0 : r_kalan - 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_durum   <= GIRIS;
            r_idx     <= '0;
            r_eslesme <= '0;
            r_acik    <= 1'b0;
            r_hata    <= 1'b0;
            r_kalan   <= KALAN_W'(MAX_DENEME);
            r_ceza    <= '0;
        end else begin
            r_hata <= 1'b0;
            case (r_durum)
                GIRIS: begin
                    // Abort wins over a simultaneous accept.
                    if (i_iptal) begin
                        r_idx     <= '0;
                        r_eslesme <= '0;
                    end else if (w_kabul) begin
                        r_eslesme[r_idx] <= (w_kod == w_sifre);
                        if (w_son_adim) begin
                            r_idx   <= '0;
                            r_durum <= KONTROL;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                KONTROL: begin
                    r_eslesme <= '0;
                    if (&r_eslesme) begin
                        r_acik  <= 1'b1;
                        r_kalan <= KALAN_W'(MAX_DENEME);
                        r_durum <= ACIK;
                    end else begin
                        r_hata  <= 1'b1;
                        r_kalan <= w_kalan_yeni;
                        if (w_kalan_yeni == '0) begin
                            r_ceza  <= CEZA_W'(CEZA_SURESI);
                            r_durum <= KILITLI;
                        end else begin
                            r_durum <= GIRIS;
                        end
                    end
                end
                ACIK: begin
                    if (i_kapat) begin
                        r_acik  <= 1'b0;
                        r_idx   <= '0;
                        r_durum <= GIRIS;
                    end
                end
                KILITLI: begin
                    // Leaves on the CEZA_SURESI-th cycle spent here.
                    if (r_ceza <= CEZA_W'(1)) begin
                        r_ceza  <= '0;
                        r_kalan <= KALAN_W'(MAX_DENEME);
                        r_durum <= GIRIS;
                    end else begin
                        r_ceza <= r_ceza - 1'b1;
                    end
                end
                default: r_durum <= GIRIS;
            endcase
        end
    end

    assign o_adim_hazir    = w_hazir;
    assign o_kilitler_acik = r_acik;
    assign o_hata          = r_hata;
    assign o_kilitli       = (r_durum == KILITLI);
    assign o_kalan_deneme  = r_kalan;

endmodule

// File: tb/tb_sirali_kilit_denetleyici.sv
// Directed bench for the multi-lock controller, default parameters.
module tb_sirali_kilit_denetleyici;

    logic        clk;
    logic        rst;
    logic        gecerli;
    logic        hazir;
    logic [2:0]  sag;
    logic [1:0]  sol;
    logic [11:0] sifre;
    logic        iptal;
    logic        kapat;
    logic        acik;
    logic        hata;
    logic        kilitli;
    logic [1:0]  kalan;

    int n_pass  = 0;
    int n_total = 0;

    sirali_kilit_denetleyici dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_adim_gecerli   (gecerli),
        .o_adim_hazir     (hazir),
        .i_sag_adim       (sag),
        .i_sol_adim       (sol),
        .i_kilit_sifreler (sifre),
        .i_iptal          (iptal),
        .i_kapat          (kapat),
        .o_kilitler_acik  (acik),
        .o_hata           (hata),
        .o_kilitli        (kilitli),
        .o_kalan_deneme   (kalan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one step across exactly one rising edge; returns on the following negedge.
    task automatic adim(input logic [2:0] s, input logic [1:0] l);
        @(negedge clk);
        sag = s; sol = l; gecerli = 1'b1;
        @(negedge clk);
        gecerli = 1'b0;
    endtask

    task automatic reset_uygula();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; gecerli = 1'b0; sag = '0; sol = '0; iptal = 1'b0; kapat = 1'b0;
        sifre = {6'd20, 6'd15};
        #3;
        n_total++;
        if ({hazir, acik, hata, kilitli, kalan} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3})
            $display("FAIL reset_outputs got=%b want=%b", {hazir, acik, hata, kilitli, kalan}, 6'b100011);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_acma();
        adim(3'd5, 2'd1);
        adim(3'd2, 2'd3);
        // One edge after the last accept: still in KONTROL
        n_total++;
        if ({acik, hazir} !== 2'b00) $display("FAIL open_latency1 got=%b want=00", {acik, hazir});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({acik, hata, kalan} !== {1'b1, 1'b0, 2'd3})
            $display("FAIL open_asserted got=%b want=%b", {acik, hata, kalan}, 4'b1011);
        else n_pass++;
    endtask

    task automatic test_kapat_hata();
        @(negedge clk); iptal = 1'b1;        // iptal ignored while open
        @(negedge clk); iptal = 1'b0;
        n_total++;
        if (acik !== 1'b1) $display("FAIL iptal_in_open got=%b want=1", acik);
        else n_pass++;
        kapat = 1'b1;
        @(negedge clk); kapat = 1'b0;
        n_total++;
        if ({acik, hazir} !== 2'b01) $display("FAIL kapat got=%b want=01", {acik, hazir});
        else n_pass++;
        adim(3'd5, 2'd1);
        adim(3'd0, 2'd0);
        @(negedge clk);
        n_total++;
        if ({hata, kalan, acik} !== {1'b1, 2'd2, 1'b0})
            $display("FAIL wrong_attempt got=%b want=%b", {hata, kalan, acik}, 4'b1100);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({hata, hazir} !== 2'b01) $display("FAIL hata_one_cycle got=%b want=01", {hata, hazir});
        else n_pass++;
    endtask

    task automatic yanlis_deneme();
        adim(3'd0, 2'd0);
        adim(3'd0, 2'd0);
        @(negedge clk);
    endtask

    task automatic test_kilitleme();
        int cnt;
        int hazir_hata;
        reset_uygula();
        yanlis_deneme();
        n_total++;
        if (kalan !== 2'd2) $display("FAIL lock_try1 kalan got=%0d want=2", kalan);
        else n_pass++;
        yanlis_deneme();
        n_total++;
        if (kalan !== 2'd1) $display("FAIL lock_try2 kalan got=%0d want=1", kalan);
        else n_pass++;
        yanlis_deneme();
        n_total++;
        if ({kilitli, hata, kalan, hazir} !== {1'b1, 1'b1, 2'd0, 1'b0})
            $display("FAIL lock_enter got=%b want=%b", {kilitli, hata, kalan, hazir}, 5'b11000);
        else n_pass++;
        // Hold a correct step valid the whole time; it must be ignored.
        sag = 3'd5; sol = 2'd1; gecerli = 1'b1; iptal = 1'b1; kapat = 1'b1;
        cnt = 0; hazir_hata = 0;
        while (kilitli === 1'b1 && cnt < 40) begin
            cnt++;
            if (hazir !== 1'b0) hazir_hata++;
            @(negedge clk);
        end
        gecerli = 1'b0; iptal = 1'b0; kapat = 1'b0;
        n_total++;
        if (cnt !== 16) $display("FAIL lock_length got=%0d want=16", cnt);
        else n_pass++;
        n_total++;
        if (hazir_hata !== 0) $display("FAIL lock_hazir got=%0d cycles ready want=0", hazir_hata);
        else n_pass++;
        n_total++;
        if ({kalan, hazir, kilitli} !== {2'd3, 1'b1, 1'b0})
            $display("FAIL lock_exit got=%b want=%b", {kalan, hazir, kilitli}, 4'b1110);
        else n_pass++;
    endtask

    task automatic test_iptal();
        adim(3'd5, 2'd1);
        @(negedge clk);
        sag = 3'd2; sol = 2'd3; gecerli = 1'b1; iptal = 1'b1;
        @(negedge clk);
        gecerli = 1'b0; iptal = 1'b0;
        @(negedge clk);
        n_total++;
        if ({hazir, hata, kalan} !== {1'b1, 1'b0, 2'd3})
            $display("FAIL iptal_no_accept got=%b want=%b", {hazir, hata, kalan}, 4'b1011);
        else n_pass++;
        // idx back at 0: (5,1) must go to lock 0 again
        adim(3'd5, 2'd1);
        adim(3'd2, 2'd3);
        @(negedge clk);
        n_total++;
        if ({acik, hata} !== 2'b10) $display("FAIL iptal_then_open got=%b want=10", {acik, hata});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        // Currently open
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({acik, hazir, kilitli, kalan} !== {1'b0, 1'b1, 1'b0, 2'd3})
            $display("FAIL rst_in_open got=%b want=%b", {acik, hazir, kilitli, kalan}, 5'b01011);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        yanlis_deneme(); yanlis_deneme(); yanlis_deneme();
        @(negedge clk); @(negedge clk);
        n_total++;
        if (kilitli !== 1'b1) $display("FAIL rst_setup_lock got=%b want=1", kilitli);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({kilitli, hazir, hata, kalan, acik} !== {1'b0, 1'b1, 1'b0, 2'd3, 1'b0})
            $display("FAIL rst_in_lock got=%b want=%b", {kilitli, hazir, hata, kalan, acik}, 6'b010110);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_wrap();
        sifre = {6'd20, 6'd10};
        adim(3'd0, 2'd3);   // d = 2, kod = 10
        adim(3'd2, 2'd3);   // d = 4, kod = 20
        @(negedge clk);
        n_total++;
        if ({acik, hata, kalan} !== {1'b1, 1'b0, 2'd3})
            $display("FAIL wrap_open got=%b want=%b", {acik, hata, kalan}, 4'b1011);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_acma();
        test_kapat_hata();
        test_kilitleme();
        test_iptal();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
